// File: rtl/tia_input_ctrl.sv
// TIA input control: fire-button follow/latch sequencing, paddle dump/charge timing, INPT read mux.
// Optional fire debounce is built when TIA_INPUT_DEBOUNCE_EN is defined.
module tia_input_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int PADDLE_W        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  input  logic [1:0]            i_fire_n,
  input  logic [2*PADDLE_W-1:0] i_paddle_pos,
  output logic [1:0]            o_follow,
  output logic [1:0]            o_latch,
  output logic [1:0]            o_inpt_fire,
  output logic [1:0]            o_inpt_paddle,
  input  logic [2:0]            i_rd_addr,
  output logic [7:0]            o_rd_data
);

  // state    | meaning
  // FOLLOW   | tia_l cells transparent, inpt_fire tracks the buttons
  // GAP_L    | both controls low for one cycle before latching
  // LATCH    | cells hold; a press sticks until FOLLOW resumes
  // GAP_F    | both controls low for one cycle before following
  typedef enum logic [1:0] {ST_FOLLOW, ST_GAP_L, ST_LATCH, ST_GAP_F} state_t;

  state_t              r_state;
  logic                r_latch_en;
  logic                r_dump;
  logic [1:0]          r_follow;
  logic [1:0]          r_latch;
  logic [1:0]          r_inpt_fire;
  logic [1:0]          r_inpt_paddle;
  logic [7:0]          r_rd_data;
  logic [1:0]          r_sync [SYNC_STAGES];
  logic [PADDLE_W-1:0] r_pcnt [2];
  logic [1:0]          w_fire_s;
  logic [1:0]          w_fire_q;
  logic                w_rd_bit;
  logic                w_unused_wr_bits;

  assign w_unused_wr_bits = ^i_wr_data[5:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_latch_en <= 1'b0;
      r_dump     <= 1'b0;
    end else if (i_wr_en) begin
      r_latch_en <= i_wr_data[6];
      r_dump     <= i_wr_data[7];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= 2'b11;
    end else begin
      r_sync[0] <= i_fire_n;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_fire_s = r_sync[SYNC_STAGES-1];

`ifdef TIA_INPUT_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_deb;
  logic [DB_W-1:0] r_db_cnt [2];

  // Down-counter reloads whenever the input agrees; terminal count accepts the change.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_deb <= 2'b11;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= DB_LOAD;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_fire_s[i] == r_deb[i]) begin
          r_db_cnt[i] <= DB_LOAD;
        end else if (r_db_cnt[i] == '0) begin
          r_deb[i]    <= w_fire_s[i];
          r_db_cnt[i] <= DB_LOAD;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign w_fire_q = r_deb;
`else
  assign w_fire_q = w_fire_s;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_FOLLOW;
      r_follow    <= 2'b11;
      r_latch     <= 2'b00;
      r_inpt_fire <= 2'b11;
    end else begin
      case (r_state)
        ST_FOLLOW: begin
          if (r_latch_en) begin
            r_state     <= ST_GAP_L;
            r_follow    <= 2'b00;
            r_inpt_fire <= 2'b11;
          end else begin
            r_inpt_fire <= w_fire_q;
          end
        end
        ST_GAP_L: begin
          r_state     <= ST_LATCH;
          r_latch     <= 2'b11;
          r_inpt_fire <= r_inpt_fire & w_fire_q;
        end
        ST_LATCH: begin
          r_inpt_fire <= r_inpt_fire & w_fire_q;
          if (!r_latch_en) begin
            r_state <= ST_GAP_F;
            r_latch <= 2'b00;
          end
        end
        ST_GAP_F: begin
          r_state     <= ST_FOLLOW;
          r_follow    <= 2'b11;
          r_inpt_fire <= w_fire_q;
        end
        default: begin
          r_state  <= ST_FOLLOW;
          r_follow <= 2'b11;
          r_latch  <= 2'b00;
        end
      endcase
    end
  end

  // Counters saturate so a far threshold stays reached instead of wrapping.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_inpt_paddle <= 2'b00;
      for (int i = 0; i < 2; i++) r_pcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_dump) begin
          r_pcnt[i]        <= '0;
          r_inpt_paddle[i] <= 1'b0;
        end else begin
          if (r_pcnt[i] != {PADDLE_W{1'b1}}) r_pcnt[i] <= r_pcnt[i] + PADDLE_W'(1);
          r_inpt_paddle[i] <= (r_pcnt[i] >= i_paddle_pos[i*PADDLE_W +: PADDLE_W]);
        end
      end
    end
  end

  always_comb begin
    w_rd_bit = 1'b0;
    case (i_rd_addr)
      3'd0:    w_rd_bit = r_inpt_paddle[0];
      3'd1:    w_rd_bit = r_inpt_paddle[1];
      3'd4:    w_rd_bit = r_inpt_fire[0];
      3'd5:    w_rd_bit = r_inpt_fire[1];
      default: w_rd_bit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_rd_data <= 8'h00;
    else         r_rd_data <= {w_rd_bit, 7'b0};
  end

  assign o_follow      = r_follow;
  assign o_latch       = r_latch;
  assign o_inpt_fire   = r_inpt_fire;
  assign o_inpt_paddle = r_inpt_paddle;
  assign o_rd_data     = r_rd_data;

endmodule

// File: tb/tb_tia_input_ctrl.sv
// Scoreboard bench for tia_input_ctrl: expectations queued with stimulus, drained after the DUT settles.
module tb_tia_input_ctrl;
  localparam int SYNC = 2;
  localparam int PW   = 8;
  localparam int DEB  = 4;
`ifdef TIA_INPUT_DEBOUNCE_EN
  localparam int LAT   = SYNC + 1 + DEB;
  localparam int PULSE = 3 + DEB;
`else
  localparam int LAT   = SYNC + 1;
  localparam int PULSE = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [1:0]    fire_n;
  logic [2*PW-1:0] pos;
  logic [1:0]    follow, latch, inpt_fire, inpt_paddle;
  logic [2:0]    rd_addr;
  logic [7:0]    rd_data;

  int n_total = 0;
  int n_bad   = 0;
  int n_ovl   = 0;

  typedef struct {string tag; int sel; logic [7:0] val;} sb_t;
  sb_t sb_q[$];

  tia_input_ctrl #(.SYNC_STAGES(SYNC), .PADDLE_W(PW), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clock(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_fire_n(fire_n), .i_paddle_pos(pos), .o_follow(follow), .o_latch(latch),
    .o_inpt_fire(inpt_fire), .o_inpt_paddle(inpt_paddle), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst === 1'b0 && (follow & latch) != 2'b00) n_ovl++;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      0: return {6'b0, follow};
      1: return {6'b0, latch};
      2: return {6'b0, inpt_fire};
      3: return {6'b0, inpt_paddle};
      4: return rd_data;
      default: return n_ovl[7:0];
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [7:0] v);
    sb_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; fire_n = 2'b11;
    pos = {8'd0, 8'd10}; rd_addr = 3'd0;
    #2 rst = 1'b1;
    sb_push("rst_follow", 0, 8'h03); sb_push("rst_latch", 1, 8'h00);
    sb_push("rst_fire", 2, 8'h03); sb_push("rst_paddle", 3, 8'h00);
    sb_push("rst_rd", 4, 8'h00);
    #2 sb_drain();
    tick(2);
    rst = 1'b0;

    // follow mode press / release latency
    fire_n = 2'b10;
    tick(LAT - 1); sb_push("t2_press_early", 2, 8'h03); sb_drain();
    tick(1);       sb_push("t2_press", 2, 8'h02); sb_drain();
    rd_addr = 3'd4;
    tick(1);       sb_push("t2_rd4_pressed", 4, 8'h00); sb_drain();
    fire_n = 2'b11;
    tick(LAT - 1); sb_push("t2_rel_early", 2, 8'h02); sb_drain();
    tick(1);       sb_push("t2_rel", 2, 8'h03); sb_drain();
    rd_addr = 3'd5;
    tick(1);       sb_push("t6_rd5", 4, 8'h80); sb_drain();

    // latch sequence
    write(8'h40);  sb_push("t3_still_follow", 0, 8'h03); sb_drain();
    tick(1);       sb_push("t3_gapl_follow", 0, 8'h00); sb_push("t3_gapl_latch", 1, 8'h00); sb_drain();
    tick(1);       sb_push("t3_latch", 1, 8'h03); sb_push("t3_latch_follow", 0, 8'h00); sb_drain();
    fire_n = 2'b01;
    tick(PULSE);
    fire_n = 2'b11;
    tick(LAT + 2); sb_push("t3_stuck", 2, 8'h01); sb_drain();
    tick(5);       sb_push("t3_still_stuck", 2, 8'h01); sb_drain();
    write(8'h00);  sb_push("t3_hold_latch", 1, 8'h03); sb_drain();
    tick(1);       sb_push("t3_gapf_follow", 0, 8'h00); sb_push("t3_gapf_latch", 1, 8'h00);
                   sb_push("t3_gapf_fire", 2, 8'h01); sb_drain();
    tick(1);       sb_push("t3_back_follow", 0, 8'h03); sb_push("t3_back_fire", 2, 8'h03); sb_drain();
    fire_n = 2'b01;
    tick(LAT);     sb_push("t3_track_press", 2, 8'h01); sb_drain();
    fire_n = 2'b11;
    tick(LAT);     sb_push("t3_track_rel", 2, 8'h03); sb_drain();

    // latch_en toggled back on the very next cycle
    wr_en = 1'b1; wr_data = 8'h40;
    tick(1);
    wr_data = 8'h00;
    tick(1);       wr_en = 1'b0;
                   sb_push("t4_gapl_f", 0, 8'h00); sb_push("t4_gapl_l", 1, 8'h00); sb_drain();
    tick(1);       sb_push("t4_latch_f", 0, 8'h00); sb_push("t4_latch_l", 1, 8'h03); sb_drain();
    tick(1);       sb_push("t4_gapf_f", 0, 8'h00); sb_push("t4_gapf_l", 1, 8'h00); sb_drain();
    tick(1);       sb_push("t4_follow_f", 0, 8'h03); sb_push("t4_follow_l", 1, 8'h00); sb_drain();

    // paddle dump/charge
    rd_addr = 3'd1;
    write(8'h80);  sb_push("t5_rd_prewrite", 4, 8'h80); sb_drain();
    write(8'h00);  sb_push("t5_dumped", 3, 8'h00); sb_drain();
    tick(1);       sb_push("t5_ch1_first", 3, 8'h02); sb_drain();
    tick(9);       sb_push("t5_ch0_early", 3, 8'h02); sb_drain();
    tick(1);       sb_push("t5_ch0_charged", 3, 8'h03); sb_drain();
    write(8'h80);  sb_push("t5_redump_lag", 3, 8'h03); sb_drain();
    tick(1);       sb_push("t5_redump", 3, 8'h00); sb_drain();
    rd_addr = 3'd0;
    tick(1);       sb_push("t5_rd0_dumped", 4, 8'h00); sb_drain();

    // saturating counter with an all-ones threshold
    pos = {8'd0, 8'd255};
    write(8'h00);
    tick(255);     sb_push("sat_early", 3, 8'h02); sb_drain();
    tick(1);       sb_push("sat_reached", 3, 8'h03); sb_drain();
    tick(44);      sb_push("sat_hold", 3, 8'h03); sb_drain();
    tick(1);       sb_push("rd0_charged", 4, 8'h80); sb_drain();
    rd_addr = 3'd3;
    tick(1);       sb_push("rd3_unmapped", 4, 8'h00); sb_drain();
    rd_addr = 3'd6;
    tick(1);       sb_push("rd6_unmapped", 4, 8'h00); sb_drain();

`ifdef TIA_INPUT_DEBOUNCE_EN
    fire_n = 2'b10;
    tick(2);
    fire_n = 2'b11;
    for (int k = 0; k < LAT + 2; k++) begin
      tick(1); sb_push("deb_glitch", 2, 8'h03); sb_drain();
    end
`endif

    // async reset while latched with a held press
    fire_n = 2'b10;
    rd_addr = 3'd0;
    write(8'h40);
    tick(LAT + 3); sb_push("t1_pre_latch", 1, 8'h03); sb_push("t1_pre_fire", 2, 8'h02);
                   sb_push("t1_pre_rd", 4, 8'h80); sb_drain();
    #2 rst = 1'b1;
    #1;
    sb_push("t1_follow", 0, 8'h03); sb_push("t1_latch", 1, 8'h00);
    sb_push("t1_fire", 2, 8'h03); sb_push("t1_rd", 4, 8'h00); sb_push("t1_paddle", 3, 8'h00);
    sb_drain();

    sb_push("overlap", 5, 8'h00); sb_drain();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
